serial_adder: RTL and testbench

// Bit-serial WIDTH-bit adder built around the existing single-bit full_adder plus a carry flip-flop.

---
 rtl/serial_adder_pkg.sv | 22 ++
 rtl/serial_adder_full_adder.sv | 23 ++
 rtl/serial_adder.sv | 143 ++++++++++++++
 tb/tb_serial_adder.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg
// Shared types and constants for the bit-serial adder.
//   sa_state_t        : controller states (IDLE, RUN, DONE)
//   SA_DEFAULT_WIDTH  : default operand/result width
//   sa_cnt_width      : width of the bit counter for a given operand width
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sa_state_t;

  localparam int SA_DEFAULT_WIDTH = 8;

  // The counter only has to reach WIDTH-1, so $clog2(WIDTH) bits are enough.
  // WIDTH >= 2 keeps this at least one bit wide.
  function automatic int sa_cnt_width(input int width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/serial_adder_full_adder.sv
// full_adder
// Single-bit full adder cell used as the arithmetic core of serial_adder.
// Ports:
//   a, b   in  1  operand bits
//   c_in   in  1  carry into this bit position
//   sum    out 1  a ^ b ^ c_in
//   c_out  out 1  carry out of this bit position
module full_adder (
  input  logic a,
  input  logic b,
  input  logic c_in,
  output logic sum,
  output logic c_out
);

  logic half_sum;

  // Carry is generated by a&b or propagated when exactly one operand is set.
  assign half_sum = a ^ b;
  assign sum      = half_sum ^ c_in;
  assign c_out    = (a & b) | (c_in & half_sum);

endmodule

// File: rtl/serial_adder.sv
// serial_adder
// Bit-serial WIDTH-bit adder: operands are captured through a valid/ready
// handshake, added one bit per clock (LSB first) with a single full_adder
// cell and a carry flip-flop, and the result {c_out, sum_out} is offered
// through a valid/ready output handshake.
// Ports:
//   clk        in   1      clock, rising edge
//   rst        in   1      synchronous reset, active-high
//   in_valid   in   1      a_in/b_in/c_in are valid
//   in_ready   out  1      operands can be accepted (IDLE only)
//   a_in       in   WIDTH  operand A
//   b_in       in   WIDTH  operand B
//   c_in       in   1      carry-in
//   out_valid  out  1      result valid (DONE only)
//   out_ready  in   1      consumer accepts the result
//   sum_out    out  WIDTH  sum bits of a_in + b_in + c_in
//   c_out      out  1      carry-out (bit WIDTH of the full sum)
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = SA_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             c_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum_out,
  output logic             c_out
);

  localparam int CNT_W = sa_cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  sa_state_t state;
  sa_state_t next_state;

  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] sum_sr;
  logic             carry;
  logic [CNT_W-1:0] cnt;

  // Result registers: only written on the final RUN edge, so the outputs keep
  // their last-registered value while IDLE and RUN.
  logic [WIDTH-1:0] res_sum;
  logic             res_co;

  logic fa_sum;
  logic fa_c_out;
  logic last_bit;

  assign last_bit = (cnt == CNT_LAST);

  full_adder u_fa (
    .a     (a_sr[0]),
    .b     (b_sr[0]),
    .c_in  (carry),
    .sum   (fa_sum),
    .c_out (fa_c_out)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic. A result being consumed in DONE always returns to IDLE,
  // so new operands can never be taken on the same edge as the hand-off.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (in_valid)  next_state = RUN;
      RUN:  if (last_bit)  next_state = DONE;
      DONE: if (out_ready) next_state = IDLE;
      default:             next_state = IDLE;
    endcase
  end

  // Output decode.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE:    in_ready  = 1'b1;
      DONE:    out_valid = 1'b1;
      default: begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
      end
    endcase
  end

  // Datapath: load on accept, then shift one bit per RUN edge. The sum bit
  // enters at the MSB so that after WIDTH shifts the LSB lands at bit 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sr    <= '0;
      b_sr    <= '0;
      sum_sr  <= '0;
      carry   <= 1'b0;
      cnt     <= '0;
      res_sum <= '0;
      res_co  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_sr  <= a_in;
            b_sr  <= b_in;
            carry <= c_in;
            cnt   <= '0;
          end
        end
        RUN: begin
          sum_sr <= {fa_sum, sum_sr[WIDTH-1:1]};
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          carry  <= fa_c_out;
          cnt    <= cnt + CNT_W'(1);
          if (last_bit) begin
            res_sum <= {fa_sum, sum_sr[WIDTH-1:1]};
            res_co  <= fa_c_out;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign sum_out = res_sum;
  assign c_out   = res_co;

endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder
// Self-checking bench for serial_adder (WIDTH=8): reset values, a table of
// directed vectors, back-pressure, reset mid-operation and a random sweep
// compared against plain arithmetic a + b + ci.
module tb_serial_adder;

  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a_in;
  logic [W-1:0] b_in;
  logic         c_in;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum_out;
  logic         c_out;

  int tests;
  int failures;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         ci;
    logic [W-1:0] sum;
    logic         co;
    int           stall;
  } vec_t;

  vec_t vecs[6];

  serial_adder #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a_in      (a_in),
    .b_in      (b_in),
    .c_in      (c_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum_out   (sum_out),
    .c_out     (c_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case something wedges the run.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // One complete operation: accept, W RUN cycles, optional stall in DONE,
  // then hand-off. The expected full sum also gives the bit the full adder
  // must produce in each RUN cycle.
  task automatic apply_stimulus(input logic [W-1:0] a, input logic [W-1:0] b,
                                input logic ci, input logic [W-1:0] exp_sum,
                                input logic exp_co, input int stall,
                                input string tag);
    logic [W:0] expv;
    int         waited;
    expv = {exp_co, exp_sum};
    check_output({tag, " in_ready before accept"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    a_in     = a;
    b_in     = b;
    c_in     = ci;
    tick();
    in_valid = 1'b0;
    a_in     = ~a;
    b_in     = W'($urandom);
    c_in     = ~ci;
    for (int k = 0; k < W; k++) begin
      check_output({tag, " out_valid low in RUN"}, 32'(out_valid), 32'd0);
      check_output({tag, " in_ready low in RUN"}, 32'(in_ready), 32'd0);
      check_output({tag, " fa sum bit"}, 32'(dut.u_fa.sum), 32'(expv[k]));
      tick();
    end
    check_output({tag, " out_valid at latency W"}, 32'(out_valid), 32'd1);
    waited = 0;
    while (out_valid !== 1'b1 && waited < 20) begin
      tick();
      waited++;
    end
    check_output({tag, " result"}, 32'({c_out, sum_out}), 32'(expv));
    for (int s = 0; s < stall; s++) begin
      tick();
      check_output({tag, " stall out_valid"}, 32'(out_valid), 32'd1);
      check_output({tag, " stall result"}, 32'({c_out, sum_out}), 32'(expv));
      check_output({tag, " stall in_ready"}, 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check_output({tag, " out_valid after hand-off"}, 32'(out_valid), 32'd0);
    check_output({tag, " in_ready after hand-off"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic         rci;
    logic [W:0]   rsum;
    int           seen_valid;

    tests     = 0;
    failures  = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a_in      = '0;
    b_in      = '0;
    c_in      = 1'b0;

    vecs[0] = '{a: 8'h00, b: 8'h00, ci: 1'b0, sum: 8'h00, co: 1'b0, stall: 0};
    vecs[1] = '{a: 8'hFF, b: 8'h01, ci: 1'b0, sum: 8'h00, co: 1'b1, stall: 0};
    vecs[2] = '{a: 8'h3C, b: 8'h0F, ci: 1'b1, sum: 8'h4C, co: 1'b0, stall: 1};
    vecs[3] = '{a: 8'hFF, b: 8'hFF, ci: 1'b1, sum: 8'hFF, co: 1'b1, stall: 0};
    vecs[4] = '{a: 8'h00, b: 8'h00, ci: 1'b1, sum: 8'h01, co: 1'b0, stall: 2};
    vecs[5] = '{a: 8'h7F, b: 8'h80, ci: 1'b0, sum: 8'hFF, co: 1'b0, stall: 0};

    // Reset held for two edges, then released.
    tick();
    tick();
    check_output("reset in_ready", 32'(in_ready), 32'd1);
    check_output("reset out_valid", 32'(out_valid), 32'd0);
    check_output("reset sum_out", 32'(sum_out), 32'h00);
    check_output("reset c_out", 32'(c_out), 32'd0);
    rst = 1'b0;
    tick();
    check_output("post-reset in_ready", 32'(in_ready), 32'd1);
    check_output("post-reset out_valid", 32'(out_valid), 32'd0);
    check_output("post-reset result", 32'({c_out, sum_out}), 32'h000);

    // Directed vectors.
    for (int i = 0; i < 6; i++) begin
      apply_stimulus(vecs[i].a, vecs[i].b, vecs[i].ci, vecs[i].sum, vecs[i].co,
                     vecs[i].stall, $sformatf("vec%0d", i));
    end

    // Back-pressure with in_valid held high: the second operands must not be
    // taken in RUN, in DONE, or on the hand-off edge.
    in_valid = 1'b1;
    a_in     = 8'h12;
    b_in     = 8'h34;
    c_in     = 1'b0;
    tick();
    a_in = 8'h05;
    b_in = 8'h06;
    c_in = 1'b1;
    for (int k = 0; k < W; k++) begin
      tick();
    end
    for (int s = 0; s < 5; s++) begin
      check_output("bp out_valid", 32'(out_valid), 32'd1);
      check_output("bp result", 32'({c_out, sum_out}), 32'h046);
      check_output("bp in_ready", 32'(in_ready), 32'd0);
      tick();
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check_output("bp idle in_ready", 32'(in_ready), 32'd1);
    check_output("bp idle out_valid", 32'(out_valid), 32'd0);
    tick();
    in_valid = 1'b0;
    check_output("bp second accept", 32'(in_ready), 32'd0);
    for (int k = 0; k < W; k++) begin
      tick();
    end
    check_output("bp second out_valid", 32'(out_valid), 32'd1);
    check_output("bp second result", 32'({c_out, sum_out}), 32'h00C);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // Reset on the 4th RUN edge discards the operation.
    in_valid = 1'b1;
    a_in     = 8'hAA;
    b_in     = 8'h55;
    c_in     = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_output("midrst in_ready", 32'(in_ready), 32'd1);
    check_output("midrst out_valid", 32'(out_valid), 32'd0);
    seen_valid = 0;
    for (int k = 0; k < 12; k++) begin
      if (out_valid === 1'b1) seen_valid++;
      tick();
    end
    check_output("midrst out_valid never rose", 32'(seen_valid), 32'd0);
    apply_stimulus(8'h80, 8'h80, 1'b1, 8'h01, 1'b1, 0, "after-rst");

    // Random sweep against plain arithmetic.
    for (int i = 0; i < 200; i++) begin
      ra   = W'($urandom);
      rb   = W'($urandom);
      rci  = 1'($urandom);
      rsum = (W+1)'(ra) + (W+1)'(rb) + (W+1)'(rci);
      apply_stimulus(ra, rb, rci, rsum[W-1:0], rsum[W], int'($urandom_range(0, 3)),
                     $sformatf("rand%0d", i));
    end

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
